// File: rtl/spike_encoder.sv
// Converts one sample into a WINDOW_P-step spike train using either rate coding
// (LFSR-dithered threshold) or latency coding (time-to-first-spike).
module spike_encoder #(
   parameter int unsigned WIDTH_P  = 8,
   parameter int unsigned WINDOW_P = 16,
   parameter logic [15:0] SEED_P   = 16'hACE1
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [WIDTH_P-1:0]            sample_i,
   input  logic                          mode_i,
   input  logic                          valid_i,
   output logic                          ready_o,
   input  logic                          flush_i,
   output logic                          spike_o,
   output logic                          spike_valid_o,
   output logic [$clog2(WINDOW_P)-1:0]   step_o,
   output logic                          done_o,
   output logic [$clog2(WINDOW_P+1)-1:0] spike_count_o
);

   localparam int unsigned STEP_W = $clog2(WINDOW_P);
   localparam int unsigned CNT_W  = $clog2(WINDOW_P + 1);
   localparam int unsigned PROD_W = WIDTH_P + STEP_W + 1;
   localparam logic [15:0] SEED_EFF  = (SEED_P == 16'h0000) ? 16'h0001 : SEED_P;
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WINDOW_P - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ENCODE = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   logic [1:0]         state_q;
   logic [WIDTH_P-1:0] sample_q;
   logic               mode_q;
   logic [STEP_W-1:0]  t_q;
   logic [STEP_W-1:0]  step_q;
   logic [CNT_W-1:0]   count_q;
   logic [15:0]        lfsr_q;

   logic [PROD_W-1:0]  t_prod;
   logic [STEP_W-1:0]  t_lat;
   logic [15:0]        lfsr_next;
   logic               spike;

   // ~sample equals (2^WIDTH_P-1) - sample; the shifted product never exceeds WINDOW_P-1.
   always_comb begin
      t_prod = PROD_W'(~sample_i) * PROD_W'(WINDOW_P);
      t_lat  = STEP_W'(t_prod >> WIDTH_P);
   end

   always_comb begin
      lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
   end

   always_comb begin
      spike = 1'b0;
      if (state_q == ST_ENCODE) begin
         if (mode_q) spike = (step_q == t_q);
         else        spike = (sample_q > lfsr_q[15 -: WIDTH_P]);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         sample_q <= '0;
         mode_q   <= 1'b0;
         t_q      <= '0;
         step_q   <= '0;
         count_q  <= '0;
         lfsr_q   <= SEED_EFF;
      end else if (flush_i) begin
         // Abort: count and LFSR hold, any sample offered this cycle is dropped.
         state_q <= ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (valid_i) begin
                  state_q  <= ST_ENCODE;
                  sample_q <= sample_i;
                  mode_q   <= mode_i;
                  t_q      <= t_lat;
                  step_q   <= '0;
                  count_q  <= '0;
               end
            end
            ST_ENCODE: begin
               count_q <= count_q + CNT_W'(spike);
               lfsr_q  <= lfsr_next;
               step_q  <= step_q + STEP_W'(1);
               if (step_q == LAST_STEP) state_q <= ST_DONE;
            end
            ST_DONE:  state_q <= ST_IDLE;
            default:  state_q <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      ready_o       = (state_q == ST_IDLE);
      spike_valid_o = (state_q == ST_ENCODE);
      done_o        = (state_q == ST_DONE);
      spike_o       = spike;
      step_o        = step_q;
      spike_count_o = count_q;
   end

endmodule

// File: doc/spike_encoder.md
# spike_encoder

Converts one WIDTH_P-bit input sample into a spike train over a fixed window of WINDOW_P timesteps. It supports rate coding (LFSR-dithered) and latency coding (time-to-first-spike). It sits ahead of the input synapse/LIF layer: the accumulator/argmax readout turns spikes into a value, and this block turns values into spikes. Samples arrive via valid/ready. The block emits one timestep per clock, then pulses done with the window's spike count.

## Interface
- WIDTH_P, 8: sample width; legal range 1..16.
- WINDOW_P, 16: timesteps per sample; must be ≥ 2.
- SEED_P, 16'hACE1: LFSR reset value; 0 is replaced by 16'h0001.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- sample_i  in  WIDTH_P  unsigned sample.
- mode_i  in  1  0 = rate coding, 1 = latency coding; latched with sample.
- valid_i  in  1  sample_i/mode_i valid.
- ready_o  out  1  block can accept a sample.
- flush_i  in  1  synchronous abort of the current window.
- spike_o  out  1  spike for current timestep; qualified by spike_valid_o.
- spike_valid_o  out  1  high during each of the WINDOW_P encode cycles.
- step_o  out  $clog2(WINDOW_P)  current timestep index.
- done_o  out  1  one-cycle pulse after the last timestep.
- spike_count_o  out  $clog2(WINDOW_P+1)  spikes emitted in the last/current window.

## Operation
- FSM states:
  - IDLE: ready_o = 1.
  - ENCODE: spike_valid_o = 1.
  - DONE: done_o = 1.
- IDLE → ENCODE when valid_i && ready_o at a clock edge. On that edge:
  - latch sample and mode;
  - step := 0;
  - spike_count_o := 0.
- ENCODE, rate mode: spike_o = (sample > lfsr[15 -: WIDTH_P]), a strict unsigned compare.
- ENCODE, latency mode: spike_o = (step == T), where T = (((2^WIDTH_P−1) − sample) × WINDOW_P) >> WIDTH_P.
  - Compute T at full width (WIDTH_P + $clog2(WINDOW_P) + 1 bits) at acceptance and hold it.
  - T ≤ WINDOW_P−1 always, so exactly one spike per window.
- spike_o and spike_valid_o are decoded from registered state only; no combinational path from any input.
- Each ENCODE cycle:
  - spike_count_o += spike_o;
  - LFSR advances once (after the compare);
  - step += 1.
- LFSR is a 16-bit Galois register shifting right: next = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 0).
  - It advances only in ENCODE.
  - It is not reseeded per sample.
- ENCODE with step == WINDOW_P−1 → DONE. DONE → IDLE unconditionally.
- spike_count_o holds its final value from DONE until the next acceptance.
- flush_i has priority over everything except reset:
  - next state is IDLE from any state;
  - no done_o pulse;
  - spike_count_o holds its partial value;
  - LFSR keeps its value;
  - a sample presented while flush_i = 1 is not accepted.
- Reset values: state IDLE, ready_o = 1, spike_o = 0, spike_valid_o = 0, step_o = 0, done_o = 0, spike_count_o = 0, LFSR = SEED_P (or 1 if SEED_P = 0).

## Timing
- Acceptance at edge N:
  - spike_valid_o high for edges N+1 .. N+WINDOW_P (step 0 .. WINDOW_P−1);
  - done_o high for one cycle after edge N+WINDOW_P;
  - ready_o high again after edge N+WINDOW_P+1.
- Minimum sample period is WINDOW_P+2 cycles. No acceptance occurs in ENCODE or DONE.
- valid_i high while ready_o is low is ignored; sample_i needs no hold.
- Rate-mode boundaries: sample = 0 never spikes; sample = 2^WIDTH_P−1 spikes unless the LFSR top bits are all ones.
- Reset asserted mid-window forces all outputs to their reset values immediately (asynchronously).
- Reset release acts on the next edge; the first sample may be accepted on the first edge after release.

## Test plan
- Reset then hold: after rst_ni release with defaults → ready_o = 1, outputs 0, LFSR top byte 0xAC.
- Rate threshold at step 0: sample 173, mode 0 → spike_o = 1 at step 0. Repeat after a fresh reset with sample 172 → spike_o = 0 at step 0. Full window spike_count_o must match a reference LFSR model.
- Rate extremes: sample 0 → 16 spike_valid_o cycles, zero spikes, done_o pulse, spike_count_o = 0. Sample 255 → count equals the number of steps whose LFSR top byte ≠ 0xFF.
- Latency coding, mode 1:
  - sample 255 → single spike at step 0;
  - sample 0 → step 15;
  - sample 128 → T = (127×16)>>8 = 7, spike at step 7;
  - spike_count_o = 1 in all cases.
- Handshake: valid_i held high continuously → acceptances exactly 18 cycles apart. valid_i pulsed during ENCODE → ignored.
- Flush and reset mid-window:
  - flush_i at step 5 → IDLE next cycle, no done_o, ready_o = 1;
  - rst_ni low at step 9 → outputs cleared immediately, LFSR back to SEED_P.
